// File: rtl/keypad_pkg.sv
// Shared types, defaults and key map for the hex keypad scanner.
// Row/column indices are 0..3; row and column lines are active-low.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN       = 2'd0,
        PRESS_DB   = 2'd1,
        HOLD       = 2'd2,
        RELEASE_DB = 2'd3
    } kp_state_e;

    localparam int DWELL_DEFAULT    = 1000;
    localparam int DEBOUNCE_DEFAULT = 1_000_000;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'h0;
            4'b11_01: code = 4'hF;
            4'b11_10: code = 4'hE;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

    // Index of the low bit; only meaningful when exactly one bit is low.
    function automatic logic [1:0] low_row_index(input logic [3:0] rs);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rs[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/stable_counter.sv
// Stability counter: counts cycles where match holds while enabled.
// done flags the last required stable cycle; the count never wraps.
module stable_counter #(
    parameter int DEBOUNCE = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic match,
    input  logic clear,
    output logic done
);

    localparam int CW = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;

    logic [CW-1:0] cnt;

    assign done = (cnt == CW'(DEBOUNCE - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && match && !done) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hex_keypad_entry.sv
// 4x4 hex keypad scanner with press/release debounce and a 4-key history.
//   state      | meaning
//   SCAN       | rotate column drive, look for a single low row at dwell end
//   PRESS_DB   | hold column, require a stable press pattern for DEBOUNCE cycles
//   HOLD       | key accepted, wait for all rows high
//   RELEASE_DB | require all rows high for DEBOUNCE cycles before rescanning
module hex_keypad_entry
    import keypad_pkg::*;
#(
    parameter int DWELL    = DWELL_DEFAULT,
    parameter int DEBOUNCE = DEBOUNCE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic [3:0]  col,
    input  logic [3:0]  row,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [15:0] data_out
);

    localparam int DW = $clog2(DWELL);

    kp_state_e     state, state_next;
    logic [3:0]    rs_meta, rs;
    logic [1:0]    col_idx, col_idx_next;
    logic [1:0]    row_idx;
    logic [3:0]    row_pat;
    logic [DW-1:0] dwell_cnt;
    logic          dwell_end;
    logic          latch_hit, accept;
    logic          db_enable, db_match, db_clear, db_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rs_meta <= 4'hF;
            rs      <= 4'hF;
        end else begin
            rs_meta <= row;
            rs      <= rs_meta;
        end
    end

    assign col       = ~(4'b0001 << col_idx);
    assign dwell_end = (dwell_cnt == DW'(DWELL - 1));
    assign db_enable = (state == PRESS_DB) || (state == RELEASE_DB);

    stable_counter #(.DEBOUNCE(DEBOUNCE)) u_stable_counter (
        .clk    (clk),
        .reset  (reset),
        .enable (db_enable),
        .match  (db_match),
        .clear  (db_clear),
        .done   (db_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= SCAN;
            col_idx <= 2'd0;
        end else begin
            state   <= state_next;
            col_idx <= col_idx_next;
        end
    end

    always_comb begin
        state_next   = state;
        col_idx_next = col_idx;
        latch_hit    = 1'b0;
        accept       = 1'b0;
        db_clear     = 1'b0;
        db_match     = 1'b0;
        case (state)
            SCAN: begin
                if (dwell_end) begin
                    if ($onehot(~rs)) begin
                        latch_hit  = 1'b1;
                        db_clear   = 1'b1;
                        state_next = PRESS_DB;
                    end else begin
                        col_idx_next = col_idx + 2'd1;
                    end
                end
            end
            PRESS_DB: begin
                db_match = (rs == row_pat);
                if (!db_match) begin
                    state_next   = SCAN;
                    col_idx_next = col_idx + 2'd1;
                end else if (db_done) begin
                    accept     = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (rs == 4'hF) begin
                    db_clear   = 1'b1;
                    state_next = RELEASE_DB;
                end
            end
            RELEASE_DB: begin
                db_match = (rs == 4'hF);
                if (!db_match) begin
                    state_next = HOLD;
                end else if (db_done) begin
                    state_next   = SCAN;
                    col_idx_next = col_idx + 2'd1;
                end
            end
            default: state_next = SCAN;
        endcase
    end

    // Dwell counter sits at zero outside SCAN, so every SCAN entry starts fresh.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dwell_cnt <= '0;
        end else if (state != SCAN || dwell_end) begin
            dwell_cnt <= '0;
        end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_pat   <= 4'hF;
            row_idx   <= 2'd0;
            key_valid <= 1'b0;
            key_code  <= 4'h0;
            data_out  <= 16'h0000;
        end else begin
            key_valid <= accept;
            if (latch_hit) begin
                row_pat <= rs;
                row_idx <= low_row_index(rs);
            end
            if (accept) begin
                key_code <= key_map(row_idx, col_idx);
                data_out <= {data_out[11:0], key_map(row_idx, col_idx)};
            end
        end
    end

endmodule

// File: tb/tb_hex_keypad_entry.sv
// Directed bench for hex_keypad_entry with a behavioural 4x4 keypad model.
module tb_hex_keypad_entry;

    logic        clk;
    logic        reset;
    logic [3:0]  col;
    logic [3:0]  row;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] data_out;

    logic        k_en, k2_en;
    logic [1:0]  k_r, k_c, k2_r, k2_c;

    int total = 0;
    int bad   = 0;
    int pulses = 0;
    int dbl    = 0;
    logic prev_kv = 1'b0;

    hex_keypad_entry #(.DWELL(4), .DEBOUNCE(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .col       (col),
        .row       (row),
        .key_valid (key_valid),
        .key_code  (key_code),
        .data_out  (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        row = 4'hF;
        if (k_en && !col[k_c])   row[k_r]  = 1'b0;
        if (k2_en && !col[k2_c]) row[k2_r] = 1'b0;
    end

    always @(negedge clk) begin
        if (reset && key_valid) pulses <= pulses + 1;
        if (reset && key_valid && prev_kv) dbl <= dbl + 1;
        prev_kv <= reset ? key_valid : 1'b0;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_pulse(input int maxc, output int el);
        int b;
        b  = pulses;
        el = 0;
        while (pulses == b && el < maxc) begin
            step();
            el++;
        end
    endtask

    task automatic press_key(input logic [1:0] r, input logic [1:0] c, input logic [3:0] code,
                             input int hold, input logic [15:0] dexp, input string tag);
        int b, el;
        b    = pulses;
        k_r  = r;
        k_c  = c;
        k_en = 1'b1;
        wait_pulse(200, el);
        check({tag, "_seen"}, 16'(pulses - b), 16'd1);
        check({tag, "_code"}, {12'h0, key_code}, {12'h0, code});
        check({tag, "_data"}, data_out, dexp);
        repeat (hold) step();
        k_en = 1'b0;
        repeat (30) step();
        check({tag, "_once"}, 16'(pulses - b), 16'd1);
    endtask

    initial begin
        int b, el;
        k_en = 1'b0; k2_en = 1'b0;
        k_r = 2'd0; k_c = 2'd0; k2_r = 2'd0; k2_c = 2'd0;
        reset = 1'b0;
        repeat (3) step();
        check("rst_col",   {12'h0, col}, 16'h000E);
        check("rst_valid", {15'h0, key_valid}, 16'h0000);
        check("rst_code",  {12'h0, key_code}, 16'h0000);
        check("rst_data",  data_out, 16'h0000);

        // Two rows low together on column 1: ignored, column keeps rotating.
        k_r = 2'd0; k_c = 2'd1; k_en = 1'b1;
        k2_r = 2'd2; k2_c = 2'd1; k2_en = 1'b1;
        reset = 1'b1;
        repeat (3) step();
        check("rot_c0", {12'h0, col}, 16'h000E);
        step();
        check("rot_c1", {12'h0, col}, 16'h000D);
        repeat (4) step();
        check("rot_c2", {12'h0, col}, 16'h000B);
        repeat (4) step();
        check("rot_c3", {12'h0, col}, 16'h0007);
        repeat (4) step();
        check("rot_c0b", {12'h0, col}, 16'h000E);
        repeat (20) step();
        check("multi_nopulse", 16'(pulses), 16'd0);
        k_en = 1'b0; k2_en = 1'b0;
        repeat (6) step();

        press_key(2'd1, 2'd2, 4'h6, 40, 16'h0006, "key6");
        press_key(2'd0, 2'd0, 4'h1, 10, 16'h0061, "key1");
        press_key(2'd0, 2'd1, 4'h2, 10, 16'h0612, "key2");
        press_key(2'd0, 2'd3, 4'hA, 10, 16'h612A, "keyA");
        press_key(2'd3, 2'd1, 4'hF, 10, 16'h12AF, "keyF");
        press_key(2'd3, 2'd0, 4'h0, 10, 16'h2AF0, "key0");

        // Bounce on key 5: ten 3-cycle phases, ending released, then stable.
        b = pulses;
        k_r = 2'd1; k_c = 2'd1;
        for (int i = 0; i < 10; i++) begin
            k_en = (i % 2 == 0);
            repeat (3) step();
        end
        check("bounce_nopulse", 16'(pulses - b), 16'd0);
        k_en = 1'b1;
        wait_pulse(200, el);
        check("bounce_seen", 16'(pulses - b), 16'd1);
        check("bounce_delay", {15'h0, (el >= 10)}, 16'h0001);
        check("bounce_code", {12'h0, key_code}, 16'h0005);
        check("bounce_data", data_out, 16'hAF05);
        k_en = 1'b0;
        repeat (30) step();
        check("bounce_once", 16'(pulses - b), 16'd1);

        // Key 1 held across a reset pulsed during press debounce.
        b = pulses;
        reset = 1'b0;
        k_r = 2'd0; k_c = 2'd0; k_en = 1'b1;
        repeat (2) step();
        reset = 1'b1;
        repeat (9) step();
        reset = 1'b0;
        #1;
        check("midrst_valid", {15'h0, key_valid}, 16'h0000);
        check("midrst_code",  {12'h0, key_code}, 16'h0000);
        check("midrst_data",  data_out, 16'h0000);
        check("midrst_col",   {12'h0, col}, 16'h000E);
        check("midrst_nopulse", 16'(pulses - b), 16'd0);
        step();
        reset = 1'b1;
        repeat (11) step();
        check("held_rst_early", {15'h0, key_valid}, 16'h0000);
        step();
        check("held_rst_pulse", {15'h0, key_valid}, 16'h0001);
        check("held_rst_code",  {12'h0, key_code}, 16'h0001);
        check("held_rst_data",  data_out, 16'h0001);
        k_en = 1'b0;
        repeat (30) step();
        check("held_rst_once", 16'(pulses - b), 16'd1);

        // Long hold on key D with a release bounce that must fall back to HOLD.
        b = pulses;
        k_r = 2'd3; k_c = 2'd3; k_en = 1'b1;
        wait_pulse(200, el);
        check("long_seen", 16'(pulses - b), 16'd1);
        repeat (200) step();
        k_en = 1'b0;
        repeat (3) step();
        k_en = 1'b1;
        repeat (40) step();
        k_en = 1'b0;
        repeat (30) step();
        check("long_once", 16'(pulses - b), 16'd1);
        check("long_code", {12'h0, key_code}, 16'h000D);
        check("long_data", data_out, 16'h001D);
        check("no_back_to_back", 16'(dbl), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
